// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: bench/core-facing run-control signals for core_run_ctrl.
// master drives start/halt/prog_ctr; slave is the controller.
interface core_run_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 10
);
    logic             start;
    logic             halt;
    logic [PC_W-1:0]  prog_ctr;
    logic             core_rst;
    logic             core_en;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_ct;
    logic [7:0]       run_count;
    logic [PC_W-1:0]  halt_pc;

    modport master (
        output start, halt, prog_ctr,
        input  core_rst, core_en, ack, timeout, cycle_ct, run_count, halt_pc
    );
    modport slave (
        input  start, halt, prog_ctr,
        output core_rst, core_en, ack, timeout, cycle_ct, run_count, halt_pc
    );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: Moore run sequencer that gates the core, detects halt/watchdog
// abort, and records cycle count, completed-run count and halt PC.
module core_run_ctrl #(
    parameter int CNT_W   = 16,
    parameter int PC_W    = 10,
    parameter int TIMEOUT = 0
) (
    input logic             clk,
    input logic             reset,
    core_run_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, FAULT} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             timeout_q;
    logic [CNT_W-1:0] cycle_q;
    logic [7:0]       runs_q;
    logic [PC_W-1:0]  hpc_q;
    logic             wd_hit;
    logic             leave_run;

    assign wd_hit    = (TIMEOUT != 0) && (cycle_q == WD_LAST);
    assign leave_run = (state_q == RUN) && (state_d == DONE || state_d == FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Start outranks halt, and halt outranks the watchdog, in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = bus.start ? ARM : IDLE;
            ARM:         state_d = bus.start ? ARM : RUN;
            RUN:         state_d = bus.start ? ARM : bus.halt ? DONE : wd_hit ? FAULT : RUN;
            DONE, FAULT: state_d = bus.start ? ARM : state_q;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.core_rst  = (state_q == IDLE) || (state_q == ARM);
        bus.core_en   = (state_q == RUN);
        bus.ack       = (state_q == DONE) || (state_q == FAULT);
        bus.timeout   = timeout_q;
        bus.cycle_ct  = cycle_q;
        bus.run_count = runs_q;
        bus.halt_pc   = hpc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
            cycle_q   <= '0;
            runs_q    <= '0;
            hpc_q     <= '0;
        end else begin
            if (state_d == ARM)
                timeout_q <= 1'b0;
            else if (state_q == RUN && state_d == FAULT)
                timeout_q <= 1'b1;
            if (state_q == ARM)
                cycle_q <= '0;
            else if (state_q == RUN && cycle_q != '1)
                cycle_q <= cycle_q + CNT_W'(1);
            if (leave_run)
                hpc_q <= bus.prog_ctr;
            if (state_q == RUN && state_d == DONE && runs_q != 8'hFF)
                runs_q <= runs_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: three controller variants (free-running, TIMEOUT=20, CNT_W=4)
// checked every cycle against a spec-level model plus literal expectations.
module tb_core_run_ctrl;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3, M_FAULT = 4;

    typedef struct {
        int mode;
        int cyc;
        int runs;
        int hpc;
        int to;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       st[3];
    logic       hl[3];
    logic [9:0] pc[3];
    mdl_t       m[3];
    int         errors = 0;
    int         checks = 0;

    logic o_rst[3], o_en[3], o_ack[3], o_to[3];
    int   o_cyc[3], o_rc[3], o_hpc[3];

    core_run_ctrl_if #(.CNT_W(16), .PC_W(10)) b0 ();
    core_run_ctrl_if #(.CNT_W(16), .PC_W(10)) b1 ();
    core_run_ctrl_if #(.CNT_W(4),  .PC_W(10)) b2 ();

    core_run_ctrl #(.CNT_W(16), .PC_W(10), .TIMEOUT(0))  u0 (.clk(clk), .reset(rst), .bus(b0));
    core_run_ctrl #(.CNT_W(16), .PC_W(10), .TIMEOUT(20)) u1 (.clk(clk), .reset(rst), .bus(b1));
    core_run_ctrl #(.CNT_W(4),  .PC_W(10), .TIMEOUT(0))  u2 (.clk(clk), .reset(rst), .bus(b2));

    always #5 clk = ~clk;

    assign b0.start = st[0]; assign b0.halt = hl[0]; assign b0.prog_ctr = pc[0];
    assign b1.start = st[1]; assign b1.halt = hl[1]; assign b1.prog_ctr = pc[1];
    assign b2.start = st[2]; assign b2.halt = hl[2]; assign b2.prog_ctr = pc[2];

    assign o_rst[0] = b0.core_rst; assign o_en[0] = b0.core_en; assign o_ack[0] = b0.ack; assign o_to[0] = b0.timeout;
    assign o_rst[1] = b1.core_rst; assign o_en[1] = b1.core_en; assign o_ack[1] = b1.ack; assign o_to[1] = b1.timeout;
    assign o_rst[2] = b2.core_rst; assign o_en[2] = b2.core_en; assign o_ack[2] = b2.ack; assign o_to[2] = b2.timeout;
    assign o_cyc[0] = int'(b0.cycle_ct); assign o_rc[0] = int'(b0.run_count); assign o_hpc[0] = int'(b0.halt_pc);
    assign o_cyc[1] = int'(b1.cycle_ct); assign o_rc[1] = int'(b1.run_count); assign o_hpc[1] = int'(b1.halt_pc);
    assign o_cyc[2] = int'(b2.cycle_ct); assign o_rc[2] = int'(b2.run_count); assign o_hpc[2] = int'(b2.halt_pc);

    function automatic int tmo(int i);
        return i == 1 ? 20 : 0;
    endfunction

    function automatic int cmax(int i);
        return i == 2 ? 15 : 65535;
    endfunction

    function automatic mdl_t nxt(mdl_t c, logic s, logic h, int p, int i);
        mdl_t n = c;
        case (c.mode)
            M_IDLE: if (s) n.mode = M_ARM;
            M_ARM: begin
                n.cyc = 0;
                if (!s) n.mode = M_RUN;
            end
            M_RUN: begin
                n.cyc = (c.cyc + 1 > cmax(i)) ? cmax(i) : c.cyc + 1;
                if (s) n.mode = M_ARM;
                else if (h) begin
                    n.mode = M_DONE;
                    n.hpc  = p;
                    n.runs = (c.runs == 255) ? 255 : c.runs + 1;
                end else if (tmo(i) != 0 && c.cyc == tmo(i) - 1) begin
                    n.mode = M_FAULT;
                    n.hpc  = p;
                end
            end
            default: if (s) n.mode = M_ARM;
        endcase
        if (n.mode == M_ARM) n.to = 0;
        if (n.mode == M_FAULT) n.to = 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        for (int i = 0; i < 3; i++)
            if (rst) m[i] <= '{M_IDLE, 0, 0, 0, 0};
            else     m[i] <= nxt(m[i], st[i], hl[i], int'(pc[i]), i);

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d core_rst", i), int'(o_rst[i]), int'(m[i].mode == M_IDLE || m[i].mode == M_ARM));
            check($sformatf("u%0d core_en", i), int'(o_en[i]), int'(m[i].mode == M_RUN));
            check($sformatf("u%0d ack", i), int'(o_ack[i]), int'(m[i].mode == M_DONE || m[i].mode == M_FAULT));
            check($sformatf("u%0d timeout", i), int'(o_to[i]), m[i].to);
            check($sformatf("u%0d cycle_ct", i), o_cyc[i], m[i].cyc);
            check($sformatf("u%0d run_count", i), o_rc[i], m[i].runs);
            check($sformatf("u%0d halt_pc", i), o_hpc[i], m[i].hpc);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one start pulse, then n RUN cycles; the last RUN edge sees halt h and start s_end
    task automatic go(int i, int n, logic [9:0] p, bit h, bit s_end);
        st[i] = 1'b1;
        tick();
        st[i] = 1'b0;
        repeat (n) tick();
        pc[i] = p;
        hl[i] = h;
        st[i] = s_end;
        tick();
        hl[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; hl[i] = 1'b0; pc[i] = '0;
        end
        repeat (2) tick();
        check("reset core_rst", int'(b0.core_rst), 1);
        check("reset core_en", int'(b0.core_en), 0);
        check("reset ack", int'(b0.ack), 0);
        check("reset cycle_ct", o_cyc[0], 0);
        rst = 1'b0;
        tick();

        go(0, 12, 10'h03A, 1'b1, 1'b0);
        check("t2 ack", int'(b0.ack), 1);
        check("t2 cycle_ct", o_cyc[0], 12);
        check("t2 halt_pc", o_hpc[0], 'h03A);
        check("t2 run_count", o_rc[0], 1);
        check("t2 timeout", int'(b0.timeout), 0);

        go(0, 5, 10'h155, 1'b1, 1'b1);
        tick();
        check("t5 cycle_ct", o_cyc[0], 0);
        check("t5 run_count", o_rc[0], 1);
        check("t5 halt_pc", o_hpc[0], 'h03A);
        check("t5 ack", int'(b0.ack), 0);
        st[0] = 1'b0;
        repeat (7) tick();
        hl[0] = 1'b1; pc[0] = 10'h077;
        tick();
        hl[0] = 1'b0;
        check("t5 rerun cycle_ct", o_cyc[0], 7);
        check("t5 rerun run_count", o_rc[0], 2);

        go(1, 20, 10'h111, 1'b0, 1'b0);
        check("t3 ack", int'(b1.ack), 1);
        check("t3 timeout", int'(b1.timeout), 1);
        check("t3 cycle_ct", o_cyc[1], 20);
        check("t3 run_count", o_rc[1], 0);
        check("t3 halt_pc", o_hpc[1], 'h111);

        go(1, 20, 10'h222, 1'b1, 1'b0);
        check("t4 timeout", int'(b1.timeout), 0);
        check("t4 cycle_ct", o_cyc[1], 20);
        check("t4 run_count", o_rc[1], 1);

        go(2, 20, 10'h3C3, 1'b1, 1'b0);
        check("t6 cnt_w4 cycle_ct", o_cyc[2], 15);

        for (int k = 0; k < 255; k++) go(0, 1, 10'(k), 1'b1, 1'b0);
        check("t6 run_count sat", o_rc[0], 255);
        check("t6 halt_pc", o_hpc[0], 'h0FE);

        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (8) tick();
        check("t1 pre cycle_ct", o_cyc[0], 7);
        rst = 1'b1;
        #1;
        check("t1 core_en", int'(b0.core_en), 0);
        check("t1 core_rst", int'(b0.core_rst), 1);
        check("t1 cycle_ct", o_cyc[0], 0);
        check("t1 run_count", o_rc[0], 0);
        check("t1 ack", int'(b0.ack), 0);
        repeat (2) tick();
        rst = 1'b0;

        hl[0] = 1'b1; pc[0] = 10'h3FF;
        repeat (3) tick();
        hl[0] = 1'b0;
        check("idle halt ignored halt_pc", o_hpc[0], 0);
        check("idle halt ignored run_count", o_rc[0], 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
